// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV64 datapath: sequences fetch, decode, execute,
// memory and write-back phases, and tracks retired instructions and fault flags.
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_sel,
    output logic             busy,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MEM_WAIT_MAX);

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSd  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAddr,
        StMemAcc, StLdWb, StPcInc, StBranch, StTrap
    } state_e;

    state_e             state_q, state_d;
    logic               armed_q;
    logic               fetch_first_q, fetch_first_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;

    // funct3/funct7_b5 are decoded by the ALU control when alu_op=10.
    logic unused_fields;
    assign unused_fields = ^{funct3, funct7_b5};

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        imm_sel    = 2'b00;
        // The cycle right after reset is quiet: every control stays low.
        if (armed_q) begin
            unique case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    if (mem_ready) state_d = StDecode;
                end
                StDecode: begin
                    unique case (opcode)
                        OpR:         state_d = StExecR;
                        OpI:         state_d = StExecI;
                        OpLd, OpSd:  state_d = StMemAddr;
                        OpBeq:       state_d = StBranch;
                        default: begin
                            state_d   = StTrap;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                StExecR: begin
                    alu_op  = 2'b10;
                    state_d = StAluWb;
                end
                StExecI: begin
                    alu_src_b = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = StAluWb;
                end
                StAluWb: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_d   = StFetch;
                end
                StMemAddr: begin
                    alu_src_b = 1'b1;
                    imm_sel   = (opcode == OpSd) ? 2'b01 : 2'b00;
                    state_d   = StMemAcc;
                end
                StMemAcc: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OpSd);
                    if (mem_ready) state_d = (opcode == OpSd) ? StPcInc : StLdWb;
                end
                StLdWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    state_d    = StFetch;
                end
                StPcInc: begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end
                StBranch: begin
                    alu_op   = 2'b01;
                    imm_sel  = 2'b10;
                    pc_write = 1'b1;
                    pc_src   = zero;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end
                StTrap: state_d = StTrap;
                default: state_d = StFetch;
            endcase
        end
    end

    always_comb begin
        fetch_first_d = (state_d == StFetch) && ((state_q != StFetch) || !armed_q);
        retired_d     = retire ? retired_q + CNT_W'(1) : retired_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        if ((state_d == StFetch || state_d == StMemAcc) && state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_req && !mem_ready) begin
            if (wait_cnt_q != WaitMax) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q >= WaitMax - WAIT_W'(1)) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            armed_q       <= 1'b0;
            fetch_first_q <= 1'b1;
            wait_cnt_q    <= '0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            armed_q       <= 1'b1;
            fetch_first_q <= fetch_first_d;
            wait_cnt_q    <= wait_cnt_d;
            illegal_q     <= illegal_d;
            timeout_q     <= timeout_d;
            retired_q     <= retired_d;
        end
    end

    assign busy        = !(state_q == StFetch && fetch_first_q) && (state_q != StTrap);
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table plus hand-written
// sequences for memory timeout, trap hold and retired-counter wrap.
module tb_multicycle_control;

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSd  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpBad = 7'h7F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic       reg_write, mem_to_reg, alu_src_b, busy, illegal_op, mem_timeout;
    logic [1:0] alu_op, imm_sel;
    logic [7:0] retired;

    multicycle_control #(.MEM_WAIT_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_sel(imm_sel), .busy(busy), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    // {req we iord irw pcw pcs rw m2r asb alu_op[1:0] imm_sel[1:0] busy}
    logic [13:0] act_ctrl;
    assign act_ctrl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                       mem_to_reg, alu_src_b, alu_op, imm_sel, busy};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic        chk;
        logic [13:0] ctrl;
        logic [7:0]  ret;
        logic        ill;
        logic        to;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic rst, input logic [6:0] op, input logic z, input logic rdy,
                       input logic chk, input logic [13:0] ctrl, input logic [7:0] ret,
                       input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.chk = chk;
        v.ctrl = ctrl; v.ret = ret; v.ill = ill; v.to = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [6:0] op);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = op;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-reset ctrl", 32'(act_ctrl), 32'd0);
        check("post-reset retired", 32'(retired), 32'd0);
        check("post-reset illegal", 32'(illegal_op), 32'd0);
    endtask

    localparam logic [13:0] CFetch  = 14'b10010000000000;
    localparam logic [13:0] CDec    = 14'b00000000000001;

    initial begin
        // Reset and quiet cycle
        add(1, 7'd0, 0, 1, 0, 14'b0, 8'd0, 0);
        add(0, 7'd0, 0, 1, 1, 14'b0, 8'd0, 0);
        // add x3,x1,x2
        add(0, OpR, 0, 1, 1, CFetch, 8'd0, 0);
        add(0, OpR, 0, 1, 1, CDec, 8'd0, 0);
        add(0, OpR, 0, 1, 1, 14'b00000000010001, 8'd0, 0);
        add(0, OpR, 0, 1, 1, 14'b00001010000001, 8'd0, 0);
        // addi
        add(0, OpI, 0, 1, 1, CFetch, 8'd1, 0);
        add(0, OpI, 0, 1, 1, CDec, 8'd1, 0);
        add(0, OpI, 0, 1, 1, 14'b00000000110001, 8'd1, 0);
        add(0, OpI, 0, 1, 1, 14'b00001010000001, 8'd1, 0);
        // ld with three stalled access cycles (one short of timeout)
        add(0, OpLd, 0, 1, 1, CFetch, 8'd2, 0);
        add(0, OpLd, 0, 1, 1, CDec, 8'd2, 0);
        add(0, OpLd, 0, 1, 1, 14'b00000000100001, 8'd2, 0);
        add(0, OpLd, 0, 0, 1, 14'b10100000000001, 8'd2, 0);
        add(0, OpLd, 0, 0, 1, 14'b10100000000001, 8'd2, 0);
        add(0, OpLd, 0, 0, 1, 14'b10100000000001, 8'd2, 0);
        add(0, OpLd, 0, 1, 1, 14'b10100000000001, 8'd2, 0);
        add(0, OpLd, 0, 1, 1, 14'b00001011000001, 8'd2, 0);
        // sd
        add(0, OpSd, 0, 1, 1, CFetch, 8'd3, 0);
        add(0, OpSd, 0, 1, 1, CDec, 8'd3, 0);
        add(0, OpSd, 0, 1, 1, 14'b00000000100011, 8'd3, 0);
        add(0, OpSd, 0, 1, 1, 14'b11100000000001, 8'd3, 0);
        add(0, OpSd, 0, 1, 1, 14'b00001000000001, 8'd3, 0);
        // beq taken, then not taken
        add(0, OpBeq, 1, 1, 1, CFetch, 8'd4, 0);
        add(0, OpBeq, 1, 1, 1, CDec, 8'd4, 0);
        add(0, OpBeq, 1, 1, 1, 14'b00001100001101, 8'd4, 0);
        add(0, OpBeq, 0, 1, 1, CFetch, 8'd5, 0);
        add(0, OpBeq, 0, 1, 1, CDec, 8'd5, 0);
        add(0, OpBeq, 0, 1, 1, 14'b00001000001101, 8'd5, 0);
        // beq with one stalled fetch cycle: busy rises on the second fetch cycle
        add(0, OpBeq, 0, 0, 1, 14'b10000000000000, 8'd6, 0);
        add(0, OpBeq, 0, 1, 1, 14'b10010000000001, 8'd6, 0);
        add(0, OpBeq, 0, 1, 1, CDec, 8'd6, 0);
        add(0, OpBeq, 0, 1, 1, 14'b00001000001101, 8'd6, 0);
        // illegal opcode traps; mem_ready ignored afterwards
        add(0, OpBad, 0, 1, 1, CFetch, 8'd7, 0);
        add(0, OpBad, 0, 1, 1, CDec, 8'd7, 0);
        add(0, OpBad, 0, 1, 1, 14'b0, 8'd7, 1);
        add(0, OpBad, 0, 1, 1, 14'b0, 8'd7, 1);
        // reset, then a second reset in the middle of a ld access
        add(1, OpLd, 0, 1, 0, 14'b0, 8'd7, 1);
        add(0, OpLd, 0, 1, 1, 14'b0, 8'd0, 0);
        add(0, OpLd, 0, 1, 1, CFetch, 8'd0, 0);
        add(0, OpLd, 0, 1, 1, CDec, 8'd0, 0);
        add(0, OpLd, 0, 1, 1, 14'b00000000100001, 8'd0, 0);
        add(0, OpLd, 0, 0, 1, 14'b10100000000001, 8'd0, 0);
        add(1, OpLd, 0, 0, 1, 14'b10100000000001, 8'd0, 0);
        add(0, OpLd, 0, 1, 1, 14'b0, 8'd0, 0);
        add(0, OpLd, 0, 1, 1, CFetch, 8'd0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            opcode = vecs[i].op;
            zero = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d ctrl", i), 32'(act_ctrl), 32'(vecs[i].ctrl));
                check($sformatf("v%0d retired", i), 32'(retired), 32'(vecs[i].ret));
                check($sformatf("v%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
                check($sformatf("v%0d mem_timeout", i), 32'(mem_timeout), 32'(vecs[i].to));
            end
        end

        // Fetch stalls four cycles: timeout flags on the fourth, request stays up
        do_reset(OpR);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("timeout after %0d stalls", k), 32'(mem_timeout), (k == 4) ? 1 : 0);
            check($sformatf("mem_req held %0d", k), 32'(mem_req), 32'd1);
        end
        mem_ready = 1'b1;
        #1;
        check("fetch completes after timeout", 32'(ir_write), 32'd1);
        @(negedge clk);
        #1;
        check("timeout sticky", 32'(mem_timeout), 32'd1);
        check("decode after stall", 32'(act_ctrl), 32'(CDec));

        // Trap holds with no memory requests
        do_reset(OpBad);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_ready = k[0];
            #1;
            check($sformatf("trap quiet %0d", k), 32'({mem_req, busy, illegal_op}), 32'b001);
        end

        // Retired counter wraps modulo 2^8
        do_reset(OpBeq);
        mem_ready = 1'b1;
        zero = 1'b0;
        @(negedge clk);
        repeat (765) @(negedge clk);
        #1;
        check("retired 255", 32'(retired), 32'd255);
        repeat (3) @(negedge clk);
        #1;
        check("retired wrap", 32'(retired), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
